stream_demux_1ton: RTL

- Parametrised, registered 1-to-N demultiplexer for valid/ready streams.
- Routes whole packets: the select is sampled on the first beat and held until the last beat.
- Output select values with no matching port cause the packet to be dropped and counted.
- Sits between a single packet source and N consumer channels. Successor to the combinational 1-to-8 bit demux.

---
 rtl/stream_demux_pkg.sv | 25 ++
 rtl/demux_out_reg.sv | 75 +++++++
 rtl/stream_demux_1ton.sv | 118 +++++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the packet-level 1-to-N stream demultiplexer.
package stream_demux_pkg;

    // Upper bound on the channel count; one-hot vectors are built at this
    // width and sliced down to N_OUT by the user.
    localparam int MAX_OUT = 64;

    // Packet-level routing state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_e;

    // One-hot decode of a channel index; indices at or beyond n decode to zero.
    function automatic logic [MAX_OUT-1:0] onehot(input int sel, input int n);
        logic [MAX_OUT-1:0] vec;
        vec = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            vec[i] = (i == sel) && (i < n);
        end
        return vec;
    endfunction

endpackage

// File: rtl/demux_out_reg.sv
// One-entry output register: holds data, last and destination, and presents
// a one-hot valid toward the destination channel until that channel takes it.
module demux_out_reg
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [SEL_W-1:0]  in_dest,
    output logic              can_load,
    input  logic [N_OUT-1:0]  m_ready,
    output logic [N_OUT-1:0]  m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [SEL_W-1:0]  dest_q, dest_d;
    logic              dest_ready;
    logic [MAX_OUT-1:0] dest_onehot;

    // Only the destination channel's ready matters; the others are ignored.
    assign dest_ready  = m_ready[dest_q];
    assign can_load    = !full_q || dest_ready;
    assign dest_onehot = onehot(int'(dest_q), N_OUT);
    assign m_valid     = full_q ? dest_onehot[N_OUT-1:0] : '0;
    assign m_data      = data_q;
    assign m_last      = last_q;

    // Next-state: a load wins over a drain so a beat can pass every cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        full_d = full_q;
        data_d = data_q;
        last_d = last_q;
        dest_d = dest_q;
        if (load) begin
            full_d = 1'b1;
            data_d = in_data;
            last_d = in_last;
            dest_d = in_dest;
        end else if (full_q && dest_ready) begin
            full_d = 1'b0;
        end
    end

    // Register update; payload is not cleared on drain so m_data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload flops are reset as well because m_data must
            // read zero out of reset; a deeper buffer would leave storage unreset.
            full_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            dest_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            full_q <= full_d;
            data_q <= data_d;
            last_q <= last_d;
            dest_q <= dest_d;
        end
    end

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N packet demultiplexer for valid/ready streams. The select
// is sampled on a packet's first beat and held to its last; packets aimed at
// a non-existent channel are swallowed and counted.
module stream_demux_1ton
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = $clog2(N_OUT),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [SEL_W-1:0]  s_sel,
    output logic [N_OUT-1:0]  m_valid,
    input  logic [N_OUT-1:0]  m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic [CNT_W-1:0]  drop_cnt
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               accept;
    logic               load;
    logic               drop_inc;
    logic               can_load;
    logic               sel_in_range;
    logic [SEL_W-1:0]   load_dest;

    // One extra bit so N_OUT == 2^SEL_W compares correctly.
    assign sel_in_range = {1'b0, s_sel} < (SEL_W + 1)'(N_OUT);
    assign s_ready      = (state_q == DROP) ? 1'b1 : can_load;
    assign accept       = s_valid && s_ready;
    assign load_dest    = (state_q == IDLE) ? s_sel : cur_sel_q;
    assign busy         = (state_q != IDLE);
    assign drop_cnt     = drop_cnt_q;

    // Packet FSM: decides per accepted beat whether to load or discard it.
    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        load      = 1'b0;
        drop_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_in_range) begin
                        load      = 1'b1;
                        cur_sel_d = s_sel;
                        if (!s_last) state_d = ROUTE;
                    end else if (s_last) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            ROUTE: begin
                if (accept) begin
                    load = 1'b1;
                    if (s_last) state_d = IDLE;
                end
            end
            DROP: begin
                if (accept && s_last) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Dropped-packet counter saturates rather than wrapping.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    // State, held select and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_sel_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    demux_out_reg #(
        .DATA_W (DATA_W),
        .N_OUT  (N_OUT),
        .SEL_W  (SEL_W)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .in_data  (s_data),
        .in_last  (s_last),
        .in_dest  (load_dest),
        .can_load (can_load),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last)
    );

endmodule
